// File: rtl/pix_fifo.sv
// First-word-fall-through pixel FIFO with frame flush and underrun flagging.
// Define PIX_FIFO_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module pix_fifo #(
   parameter int DW = 16,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic [DW-1:0] din,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout,
   output logic [AW:0]   level,
   output logic          underrun
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
   ,
   output logic [15:0]   underrun_cnt
`endif
);

   typedef enum logic {EMPTY, VALID} state_t;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [AW:0]   wptr_d;
   logic [DW-1:0] dout_reg;
   state_t        state;
   logic          armed;
   logic          underrun_reg;
   logic          full;
   logic          wr_en;
   logic          prefetch;
   logic          underrun_next;

   always_comb begin
      full          = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      din_ready     = !full && !flush;
      wr_en         = din_valid && din_ready;
      // The read side compares against a one-cycle-delayed write pointer,
      // which sets the two-edge write-to-head latency.
      prefetch      = !flush && (wptr_d != rptr) && ((state == EMPTY) || dout_ready);
      underrun_next = dout_ready && (state == EMPTY) && armed && !flush;
      level         = wptr - rptr;
      dout_valid    = (state == VALID);
      dout          = dout_reg;
      underrun      = underrun_reg;
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         mem[wptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr         <= '0;
         rptr         <= '0;
         wptr_d       <= '0;
         dout_reg     <= '0;
         state        <= EMPTY;
         armed        <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         wptr_d       <= wptr;
         underrun_reg <= underrun_next;
         if (wr_en)
            wptr <= wptr + 1'b1;
         if (prefetch) begin
            rptr     <= rptr + 1'b1;
            dout_reg <= mem[rptr[AW-1:0]];
            state    <= VALID;
         end else if ((state == VALID) && dout_ready) begin
            dout_reg <= '0;
            state    <= EMPTY;
         end
         if (state == VALID)
            armed <= 1'b1;
      end
   end

`ifdef PIX_FIFO_UNDERRUN_CNT_EN
   logic [15:0] cnt_reg;

   // Survives flush so the count spans frames.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_reg <= '0;
      else if (underrun_next && (cnt_reg != 16'hFFFF))
         cnt_reg <= cnt_reg + 16'd1;
   end

   assign underrun_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_pix_fifo.sv
// Directed self-checking bench for pix_fifo; one task per scenario.
module tb_pix_fifo;

   localparam int DW = 16;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [DW-1:0] din = '0;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic [DW-1:0] dout;
   logic [AW:0]   level;
   logic          underrun;
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
   logic [15:0]   underrun_cnt;
`endif

   int checks = 0;
   int failures = 0;

   pix_fifo #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .din_valid(din_valid), .din_ready(din_ready), .din(din),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
      .level(level), .underrun(underrun)
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
      , .underrun_cnt(underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; din_valid = 1'b1; din = 16'hDEAD;
      tick(); tick();
      rst = 1'b0; din_valid = 1'b0;
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
      checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
      checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h want=0000", dout); end
      checks++; if (level !== 10'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", level); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b want=0", underrun); end
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
      checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h want=0000", underrun_cnt); end
`endif
      tick(); tick(); tick();
      checks++; if (dout_valid !== 1'b0 || level !== 10'd0) begin failures++; $display("FAIL reset_write_dropped valid=%b level=%0d want valid=0 level=0", dout_valid, level); end
      $display("test_reset done");
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 512; i++) begin
         din_valid = 1'b1; din = i[15:0];
         tick();
         if (i < 2) begin
            checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid edge=%0d got=%b want=0", i, dout_valid); end
         end
         if (i == 2) begin
            checks++; if (dout_valid !== 1'b1 || dout !== 16'h0000) begin failures++; $display("FAIL fill_first_head valid=%b dout=%h want valid=1 dout=0000", dout_valid, dout); end
         end
      end
      checks++; if (level !== 10'd511) begin failures++; $display("FAIL fill_level511 got=%0d want=511", level); end
      checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL fill_ready511 got=%b want=1", din_ready); end
      din = 16'h0200;
      tick();
      checks++; if (level !== 10'd512 || din_ready !== 1'b0) begin failures++; $display("FAIL fill_full level=%0d ready=%b want level=512 ready=0", level, din_ready); end
      din = 16'h0201;
      tick();
      checks++; if (level !== 10'd512 || dout !== 16'h0000) begin failures++; $display("FAIL fill_reject level=%0d dout=%h want level=512 dout=0000", level, dout); end
      // Read while full with din_valid still high: no write lands this cycle.
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0; din_valid = 1'b0;
      checks++; if (dout !== 16'h0001 || dout_valid !== 1'b1) begin failures++; $display("FAIL fill_consume dout=%h valid=%b want dout=0001 valid=1", dout, dout_valid); end
      checks++; if (level !== 10'd511 || din_ready !== 1'b1) begin failures++; $display("FAIL fill_full_read level=%0d ready=%b want level=511 ready=1", level, din_ready); end
      $display("test_fill done");
   endtask

   task automatic test_streaming();
      int exp_val = 0;
      bit started = 0;
      int bad = 0;
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         din_valid = 1'b1; dout_ready = 1'b1; din = k[15:0];
         tick();
         if (started && !dout_valid) begin
            bad++;
            if (bad < 5) $display("FAIL stream_gap cycle=%0d valid=0 want=1", k);
         end
         if (dout_valid) begin
            started = 1;
            checks++;
            if (dout !== exp_val[15:0]) begin failures++; $display("FAIL stream_data cycle=%0d got=%h want=%h", k, dout, exp_val[15:0]); end
            exp_val++;
         end
      end
      din_valid = 1'b0; dout_ready = 1'b0;
      checks++; if (bad != 0) begin failures++; $display("FAIL stream_gaps got=%0d want=0", bad); end
      checks++; if (exp_val != 1998) begin failures++; $display("FAIL stream_count got=%0d want=1998", exp_val); end
      $display("test_streaming received=%0d", exp_val);
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 101; i++) begin
         din_valid = 1'b1; din = 16'h0100 + i[15:0];
         tick();
      end
      din_valid = 1'b0;
      checks++; if (level !== 10'd100 || dout !== 16'h0100) begin failures++; $display("FAIL flush_pre level=%0d dout=%h want level=100 dout=0100", level, dout); end
      flush = 1'b1; din_valid = 1'b1; din = 16'hAAAA; dout_ready = 1'b1;
      #1;
      checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0", din_ready); end
      tick();
      flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
      checks++; if (level !== 10'd0 || dout_valid !== 1'b0 || dout !== 16'h0) begin failures++; $display("FAIL flush_clear level=%0d valid=%b dout=%h want 0/0/0000", level, dout_valid, dout); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL flush_underrun got=%b want=0", underrun); end
      din_valid = 1'b1; din = 16'h5555;
      tick();
      din_valid = 1'b0;
      tick(); tick();
      checks++; if (dout_valid !== 1'b1 || dout !== 16'h5555 || level !== 10'd0) begin failures++; $display("FAIL flush_next_head valid=%b dout=%h level=%0d want 1/5555/0", dout_valid, dout, level); end
      $display("test_flush done");
   endtask

   task automatic test_underrun();
      logic [15:0] pix [3];
      pix[0] = 16'h0011; pix[1] = 16'h0022; pix[2] = 16'h0033;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1; din = pix[i];
         tick();
      end
      din_valid = 1'b0;
      tick(); tick();
      checks++; if (dout !== 16'h0011 || level !== 10'd2) begin failures++; $display("FAIL ur_prime dout=%h level=%0d want 0011/2", dout, level); end
      dout_ready = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e <= 2) begin
            checks++; if (dout_valid !== 1'b1 || dout !== pix[e] || underrun !== 1'b0) begin failures++; $display("FAIL ur_deliver edge=%0d valid=%b dout=%h ur=%b want 1/%h/0", e, dout_valid, dout, underrun, pix[e]); end
         end else if (e == 3) begin
            checks++; if (dout_valid !== 1'b0 || dout !== 16'h0 || underrun !== 1'b0) begin failures++; $display("FAIL ur_drained valid=%b dout=%h ur=%b want 0/0000/0", dout_valid, dout, underrun); end
         end else begin
            checks++; if (underrun !== 1'b1 || dout !== 16'h0) begin failures++; $display("FAIL ur_pulse edge=%0d ur=%b dout=%h want 1/0000", e, underrun, dout); end
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
            checks++; if (underrun_cnt !== 16'(e - 3)) begin failures++; $display("FAIL ur_cnt edge=%0d got=%0d want=%0d", e, underrun_cnt, e - 3); end
`endif
         end
      end
      dout_ready = 1'b0;
      tick();
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ur_end got=%b want=0", underrun); end
      $display("test_underrun done");
   endtask

   task automatic test_unarmed();
      flush = 1'b1;
      tick();
      flush = 1'b0; dout_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL unarmed cycle=%0d ur=%b want=0", c, underrun); end
      end
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
      checks++; if (underrun_cnt !== 16'd5) begin failures++; $display("FAIL unarmed_cnt got=%0d want=5", underrun_cnt); end
`endif
      dout_ready = 1'b0;
      $display("test_unarmed done");
   endtask

`ifdef PIX_FIFO_UNDERRUN_CNT_EN
   task automatic test_saturation();
      do_reset();
      din_valid = 1'b1; din = 16'h0077;
      tick();
      din_valid = 1'b0;
      tick(); tick();
      dout_ready = 1'b1;
      tick();
      for (int c = 0; c < 65540; c++) tick();
      dout_ready = 1'b0;
      checks++; if (underrun_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%h want=ffff", underrun_cnt); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (underrun_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_flush got=%h want=ffff", underrun_cnt); end
      do_reset();
      checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL sat_rst got=%h want=0000", underrun_cnt); end
      $display("test_saturation done");
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_streaming();
      test_flush();
      test_underrun();
      test_unarmed();
`ifdef PIX_FIFO_UNDERRUN_CNT_EN
      test_saturation();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
